seq_pp_accumulator: RTL

- Sequential unsigned WIDTH x WIDTH multiplier.
- Gates the multiplicand by one multiplier bit per cycle to form each partial product (bit ? a : 0), then shift-adds it into a 2*WIDTH accumulator.
- Sits behind the gated partial-product generators as the consuming end of the partial-product path.
- Used as the low-area alternative and as a golden cross-check for the parallel Vedic mantissa multiplier.
- Has a valid/ready handshake on both input and output.

---
 rtl/seq_pp_accumulator.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_pp_accumulator.sv
// Sequential shift-add unsigned multiplier with valid/ready on both sides.
// Optional build macro SKIP_ZERO_EN: finish early once the remaining multiplier bits are zero.
module seq_pp_accumulator #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | one partial product accumulated per cycle
    // DONE  | product presented until out_ready
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_shreg;
    logic [WIDTH-1:0]   pp;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   cnt;
    logic               last;

    // Upper half plus carry takes the partial product, then the whole
    // accumulator moves right one place so the carry is never lost.
    always_comb begin
        pp       = b_shreg[0] ? a_reg : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, pp};
        acc_step = {sum, acc[WIDTH-1:1]};
`ifdef SKIP_ZERO_EN
        last     = (cnt == CNT_LAST) || (b_shreg[WIDTH-1:1] == '0);
        acc_next = last ? (acc_step >> (CNT_LAST - cnt)) : acc_step;
`else
        last     = (cnt == CNT_LAST);
        acc_next = acc_step;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_shreg <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_shreg <= b;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    b_shreg <= b_shreg >> 1;
                    cnt     <= cnt + 1'b1;
                    if (last) product <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule
